kvs_query_tx: RTL and testbench
===============================

# kvs_query_tx

Network-side initiator for the key-value lookup interface between the Ethernet path and the database. It accepts parsed 96-bit flow keys from the packet pipeline and issues them to the database as single-cycle query strobes. It tracks outstanding queries in an in-order tag FIFO and pairs each database response with the packet ID that produced it, so the forwarding logic gets a per-packet verdict. It sits in the `db_clk` domain, between the header parser and the database top.

## Interface
- `KEY_SIZE`, 96: key width in bits.
- `ID_W`, 8: packet-ID width.
- `DEPTH`, 16: maximum outstanding queries; must be a power of two, at least 2.
- `TIMEOUT`, 1024: cycles the oldest query may wait before it is retired as timed out.
- `clk`  in  1  database clock (`db_clk`).
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  parser offers a query.
- `req_ready`  out  1  query accepted when high together with `req_valid`.
- `req_key`  in  KEY_SIZE  flow key.
- `req_flag`  in  4  operation code.
- `req_id`  in  ID_W  packet tag.
- `in_key`  out  KEY_SIZE  key to the database.
- `in_flag`  out  4  operation code to the database.
- `in_valid`  out  1  one-cycle query strobe.
- `out_valid`  in  1  one-cycle database response strobe.
- `out_flag`  in  4  database response flags.
- `rsp_valid`  out  1  one-cycle verdict strobe.
- `rsp_id`  out  ID_W  tag of the retired query.
- `rsp_flag`  out  4  response flags; 0 on timeout.
- `rsp_timeout`  out  1  verdict was produced by timeout.
- `err_orphan`  out  1  sticky: a response arrived with no query outstanding.

## Operation
- Reset values: all outputs 0, except `req_ready`, which is 0 while `rst` is asserted and 1 from the first clock after release. FIFO is empty, timeout counter and stale counter are 0.
- Request accept:
  - `req_ready = !full`.
  - On `req_valid && req_ready`, `req_id` is pushed to the tag FIFO.
  - On the same edge, `in_key`/`in_flag` register the request and `in_valid` is 1 for the next cycle only.
  - `in_key`/`in_flag` hold their value between strobes.
- The database has no backpressure and answers strictly in order.
- Response (`out_valid`):
  - If the stale count is > 0, decrement it and discard the response; no verdict is produced.
  - Else, if the FIFO is non-empty, pop it and drive `rsp_valid=1`, `rsp_id=head`, `rsp_flag=out_flag`, `rsp_timeout=0`.
  - Else (FIFO empty), set `err_orphan`. It stays set until reset.
- Full case: while full, `req_ready=0`, even if a pop occurs in the same cycle; the push waits one cycle.
- Simultaneous push and pop when not full: both occur and the occupancy is unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Occupancy is `$clog2(DEPTH)+1` bits.

## Timing
- Accept at edge N: `in_valid` high in cycle N+1.
- `out_valid` in cycle M: `rsp_valid` high in cycle M+1.
- Minimum round trip is therefore 2 cycles plus the database latency.
- Throughput: one query per cycle while not full, and one verdict per cycle.
- When `rst` is asserted mid-operation, all state clears immediately (asynchronously). Responses to in-flight queries that arrive after reset are orphans and set `err_orphan`.

## Configuration
- `KVS_QUERY_TIMEOUT_EN` defined:
  - A 16-bit age counter tracks the FIFO head. It resets to 0 on every pop and while the FIFO is empty, and increments otherwise.
  - When the counter reaches `TIMEOUT-1` and no response pops in that cycle, the head is popped in the next cycle with `rsp_valid=1`, `rsp_timeout=1`, `rsp_flag=0`.
  - The stale count (`$clog2(DEPTH)+1` bits, saturating) increments so the late response is discarded.
  - If a response and a timeout occur in the same cycle, the response wins.
- Macro undefined: no age or stale counters, and the stale-count check is omitted. `rsp_timeout` is tied to 0 and queries wait indefinitely.

## Structure
- Shared package `kvs_pkg`:
  - `KEY_SIZE`.
  - Operation codes `KVS_OP_LOOKUP=4'b0001`, `KVS_OP_INSERT=4'b0010`, `KVS_OP_DELETE=4'b0100`.
  - Response bit `KVS_RSP_HIT=0`.
  - A typedef for the request struct (key, flag, id).
- One sub-module, `kvs_tag_fifo`: synchronous FIFO of width `ID_W`, depth `DEPTH`, with full/empty/head outputs and first-word-fall-through behaviour.

## Test plan
- Single lookup: key `96'h0A000001_0A000002_1F90_0050`, id 5. Expect `in_valid` one cycle later; database answers `out_flag=4'b0001` after 3 cycles. Expect `rsp_valid`, `rsp_id=5`, `rsp_flag=1` one cycle after `out_valid`.
- Burst fill: 16 back-to-back requests with ids 0..15 and responses withheld. Expect `req_ready` to fall after the 16th accept. Then 16 responses: `rsp_id` comes out 0..15 in order and `req_ready` rises the cycle after the first pop.
- Push/pop same cycle at occupancy 3: occupancy stays 3 and there is no loss or duplication of ids.
- Orphan: `out_valid` with the FIFO empty. Expect `err_orphan=1` with no `rsp_valid`; it holds until `rst` is asserted.
- Timeout, with `KVS_QUERY_TIMEOUT_EN` and `TIMEOUT=8`: id 9 with no response. Expect `rsp_valid`, `rsp_timeout=1`, `rsp_id=9` at cycle 8 after the push. A late response is discarded, and the next query's response maps correctly.
- Reset mid-burst: assert `rst` with 4 queries outstanding. All outputs go to 0 immediately; after release the FIFO is empty and `req_ready=1`.

Source files
------------

// File: rtl/kvs_pkg.sv
// kvs_pkg: shared types and constants for the key-value query path.
//   KEY_SIZE      flow key width
//   KVS_ID_W      packet tag width carried in the request struct
//   KVS_OP_*      operation codes presented on req_flag / in_flag
//   KVS_RSP_HIT   bit of the database response flags meaning "key found"
//   kvs_req_t     request payload (key, flag, id)
package kvs_pkg;

    localparam int unsigned KEY_SIZE = 96;
    localparam int unsigned KVS_ID_W = 8;

    localparam logic [3:0] KVS_OP_LOOKUP = 4'b0001;
    localparam logic [3:0] KVS_OP_INSERT = 4'b0010;
    localparam logic [3:0] KVS_OP_DELETE = 4'b0100;

    localparam int unsigned KVS_RSP_HIT = 0;

    typedef struct packed {
        logic [KEY_SIZE-1:0] key;
        logic [3:0]          flag;
        logic [KVS_ID_W-1:0] id;
    } kvs_req_t;

    // True when a database response reports a hit.
    function automatic logic rsp_is_hit(input logic [3:0] flag);
        return flag[KVS_RSP_HIT];
    endfunction

endpackage

// File: rtl/kvs_tag_fifo.sv
// kvs_tag_fifo: in-order tag FIFO with first-word-fall-through head.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, din       write din when not full
//   pop             drop head when not empty
//   head_c          current head word (valid while !empty_c)
//   empty_c         FIFO holds no entries
//   ready           registered "not full": 0 in reset, and stays 0 for the
//                   cycle in which a full FIFO is popped
module kvs_tag_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head_c,
    output logic         empty_c,
    output logic         ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          do_push_c, do_pop_c;

    // Pointer/occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        do_push_c = push && (count_q != CW'(DEPTH));
        do_pop_c  = pop && (count_q != '0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + CW'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_d = count_q - CW'(1);
        end
        ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign empty_c = (count_q == '0);
    assign ready   = ready_q;

endmodule

// File: rtl/kvs_query_tx.sv
// kvs_query_tx: issues parsed flow keys to the database as single-cycle
// query strobes and pairs each in-order database response with the packet
// tag that produced it.
// Ports:
//   clk, rst                     db_clk, asynchronous active-low reset
//   req_valid/ready/key/flag/id  query offer from the header parser
//   in_key/in_flag/in_valid      query strobe to the database
//   out_valid/out_flag           response strobe from the database
//   rsp_valid/id/flag/timeout    per-packet verdict strobe
//   err_orphan                   sticky: response with nothing outstanding
// Build option: define KVS_QUERY_TIMEOUT_EN to retire a head query that
// has waited TIMEOUT cycles and to discard its late response.
module kvs_query_tx #(
    parameter int unsigned KEY_SIZE = kvs_pkg::KEY_SIZE,
    parameter int unsigned ID_W     = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_SIZE-1:0] req_key,
    input  logic [3:0]          req_flag,
    input  logic [ID_W-1:0]     req_id,
    output logic [KEY_SIZE-1:0] in_key,
    output logic [3:0]          in_flag,
    output logic                in_valid,
    input  logic                out_valid,
    input  logic [3:0]          out_flag,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [3:0]          rsp_flag,
    output logic                rsp_timeout,
    output logic                err_orphan
);

    import kvs_pkg::*;

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned PKW = kvs_pkg::KEY_SIZE;
    localparam int unsigned PIW = KVS_ID_W;

    // Elaboration-time parameter sanity check.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2 || TIMEOUT > 65536) begin : g_bad_cfg
        $error("kvs_query_tx: DEPTH must be a power of two >= 2, TIMEOUT in 2..65536");
    end

    kvs_req_t            req_c;
    logic                push_c, pop_c, rsp_pop_c, tmo_pop_c;
    logic                fifo_ready, empty_c;
    logic [ID_W-1:0]     head_c;
    logic                stale_zero_c, tmo_hit_c;

    logic [KEY_SIZE-1:0] in_key_q, in_key_d;
    logic [3:0]          in_flag_q, in_flag_d;
    logic                in_valid_q, in_valid_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [3:0]          rsp_flag_q, rsp_flag_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                err_orphan_q, err_orphan_d;

    kvs_tag_fifo #(
        .W     (ID_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .din     (ID_W'(req_c.id)),
        .head_c  (head_c),
        .empty_c (empty_c),
        .ready   (fifo_ready)
    );

`ifdef KVS_QUERY_TIMEOUT_EN
    logic [CW-1:0] stale_q, stale_d;
    logic [15:0]   age_q, age_d;

    assign stale_zero_c = (stale_q == '0);
    assign tmo_hit_c    = !empty_c && (age_q == 16'(TIMEOUT - 1));

    // Stale count: one per timed-out query whose late response must be
    // dropped; a discard and a new timeout in the same cycle cancel out.
    always_comb begin
        stale_d = stale_q;
        if (out_valid && !stale_zero_c) begin
            stale_d = stale_q - CW'(1);
        end
        if (tmo_pop_c && (stale_d != '1)) begin
            stale_d = stale_d + CW'(1);
        end
        age_d = (pop_c || empty_c) ? 16'd0 : age_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stale_q <= '0;
            age_q   <= '0;
        end else begin
            stale_q <= stale_d;
            age_q   <= age_d;
        end
    end
`else
    assign stale_zero_c = 1'b1;
    assign tmo_hit_c    = 1'b0;
`endif

    // Accept, response pairing and verdict generation.
    always_comb begin
        req_c       = '{key: PKW'(req_key), flag: req_flag, id: PIW'(req_id)};
        push_c      = req_valid && fifo_ready;
        rsp_pop_c   = out_valid && stale_zero_c && !empty_c;
        tmo_pop_c   = tmo_hit_c && !rsp_pop_c;
        pop_c       = rsp_pop_c || tmo_pop_c;

        in_valid_d  = push_c;
        in_key_d    = in_key_q;
        in_flag_d   = in_flag_q;
        if (push_c) begin
            in_key_d  = KEY_SIZE'(req_c.key);
            in_flag_d = req_c.flag;
        end

        rsp_valid_d   = pop_c;
        rsp_timeout_d = tmo_pop_c;
        rsp_id_d      = rsp_id_q;
        rsp_flag_d    = rsp_flag_q;
        if (rsp_pop_c) begin
            rsp_id_d   = head_c;
            rsp_flag_d = out_flag;
        end else if (tmo_pop_c) begin
            rsp_id_d   = head_c;
            rsp_flag_d = 4'd0;
        end

        err_orphan_d = err_orphan_q || (out_valid && stale_zero_c && empty_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_key_q      <= '0;
            in_flag_q     <= '0;
            in_valid_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_flag_q    <= '0;
            rsp_timeout_q <= 1'b0;
            err_orphan_q  <= 1'b0;
        end else begin
            in_key_q      <= in_key_d;
            in_flag_q     <= in_flag_d;
            in_valid_q    <= in_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_flag_q    <= rsp_flag_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_orphan_q  <= err_orphan_d;
        end
    end

    assign req_ready   = fifo_ready;
    assign in_key      = in_key_q;
    assign in_flag     = in_flag_q;
    assign in_valid    = in_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_flag    = rsp_flag_q;
    assign rsp_timeout = rsp_timeout_q;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_kvs_query_tx.sv
// Testbench for kvs_query_tx: table-driven vectors, hand sequences for the
// multi-cycle corners, and randomized traffic against a queue-based model.
module tb_kvs_query_tx;

    import kvs_pkg::*;

    localparam int unsigned KW    = 96;
    localparam int unsigned IW    = 8;
    localparam int unsigned DEPTH = 16;
`ifdef KVS_QUERY_TIMEOUT_EN
    localparam int unsigned TMO   = 8;
`else
    localparam int unsigned TMO   = 1024;
`endif
    localparam int SMAX = 2 * DEPTH - 1;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [KW-1:0] req_key;
    logic [3:0]    req_flag;
    logic [IW-1:0] req_id;
    logic [KW-1:0] in_key;
    logic [3:0]    in_flag;
    logic          in_valid, out_valid;
    logic [3:0]    out_flag;
    logic          rsp_valid;
    logic [IW-1:0] rsp_id;
    logic [3:0]    rsp_flag;
    logic          rsp_timeout, err_orphan;

    kvs_query_tx #(
        .KEY_SIZE (KW),
        .ID_W     (IW),
        .DEPTH    (DEPTH),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_key     (req_key),
        .req_flag    (req_flag),
        .req_id      (req_id),
        .in_key      (in_key),
        .in_flag     (in_flag),
        .in_valid    (in_valid),
        .out_valid   (out_valid),
        .out_flag    (out_flag),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_flag    (rsp_flag),
        .rsp_timeout (rsp_timeout),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int            q[$];
    int            stale, age, db_pend;
    bit            m_ready, m_err;
    bit            e_in_valid, e_rsp_valid, e_tmo;
    logic [KW-1:0] e_key;
    logic [3:0]    e_flag, e_rsp_flag;
    int            e_rsp_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        bit            rv;
        logic [KW-1:0] key;
        logic [3:0]    flag;
        logic [IW-1:0] id;
        bit            ov;
        logic [3:0]    of;
        bit            x_inv;
        bit            x_rv;
        logic [IW-1:0] x_id;
        logic [3:0]    x_flag;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(bit rv, logic [KW-1:0] k, logic [3:0] f, logic [IW-1:0] id,
                                bit ov, logic [3:0] of, bit xi, bit xr,
                                logic [IW-1:0] xid, logic [3:0] xf);
        vec_t v;
        v.rv = rv; v.key = k; v.flag = f; v.id = id; v.ov = ov; v.of = of;
        v.x_inv = xi; v.x_rv = xr; v.x_id = xid; v.x_flag = xf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("in_valid", 128'(in_valid), 128'(e_in_valid));
        if (e_in_valid) begin
            chk("in_key", 128'(in_key), 128'(e_key));
            chk("in_flag", 128'(in_flag), 128'(e_flag));
        end
        chk("rsp_valid", 128'(rsp_valid), 128'(e_rsp_valid));
        if (e_rsp_valid) begin
            chk("rsp_id", 128'(rsp_id), 128'(e_rsp_id));
            chk("rsp_flag", 128'(rsp_flag), 128'(e_rsp_flag));
        end
        chk("rsp_timeout", 128'(rsp_timeout), 128'(e_tmo));
        chk("err_orphan", 128'(err_orphan), 128'(m_err));
        chk("req_ready", 128'(req_ready), 128'(m_ready));
    endtask

    // One clock: drive inputs, advance the model by the rules, compare.
    task automatic cycle(input bit rv, input logic [KW-1:0] k, input logic [3:0] f,
                         input logic [IW-1:0] id, input bit ov, input logic [3:0] of);
        bit acc, popped, ptmo, was_empty;
        int pid;
        logic [3:0] pflag;
        req_valid = rv; req_key = k; req_flag = f; req_id = id;
        out_valid = ov; out_flag = of;
        acc = rv && m_ready;
        popped = 1'b0; ptmo = 1'b0; pid = 0; pflag = 4'd0;
        was_empty = (q.size() == 0);
        if (ov) begin
            if (stale > 0) stale--;
            else if (q.size() > 0) begin
                pid = q.pop_front(); popped = 1'b1; pflag = of;
            end else m_err = 1'b1;
        end
`ifdef KVS_QUERY_TIMEOUT_EN
        if (!popped && !was_empty && age == int'(TMO) - 1) begin
            pid = q.pop_front(); popped = 1'b1; ptmo = 1'b1; pflag = 4'd0;
            if (stale < SMAX) stale++;
        end
        age = (popped || was_empty) ? 0 : age + 1;
`endif
        if (acc) begin
            q.push_back(int'(id)); e_key = k; e_flag = f;
        end
        e_in_valid = acc;
        e_rsp_valid = popped;
        e_tmo = ptmo;
        if (popped) begin
            e_rsp_id = pid; e_rsp_flag = pflag;
        end
        m_ready = (q.size() < int'(DEPTH));
        tick();
        check_model();
    endtask

    task automatic idle();
        cycle(1'b0, '0, 4'd0, '0, 1'b0, 4'd0);
    endtask

    // Assert reset asynchronously, check that every output clears at once.
    task automatic assert_reset();
        rst = 1'b0;
        req_valid = 1'b0; out_valid = 1'b0;
        #1;
        q.delete(); stale = 0; age = 0; db_pend = 0;
        m_err = 1'b0; m_ready = 1'b0;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_in_valid", 128'(in_valid), 128'(0));
        chk("rst_in_key", 128'(in_key), 128'(0));
        chk("rst_in_flag", 128'(in_flag), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_rsp_flag", 128'(rsp_flag), 128'(0));
        chk("rst_rsp_timeout", 128'(rsp_timeout), 128'(0));
        chk("rst_err_orphan", 128'(err_orphan), 128'(0));
    endtask

    task automatic release_reset();
        tick();
        tick();
        chk("rst_hold_ready", 128'(req_ready), 128'(0));
        rst = 1'b1;
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        logic [KW-1:0] ka, kb;
        logic [3:0]    ops[3];
        int            n;
        bit            found;
        ops[0] = KVS_OP_LOOKUP; ops[1] = KVS_OP_INSERT; ops[2] = KVS_OP_DELETE;
        ka = 96'h0A000001_0A000002_1F90_0050;
        kb = 96'hC0A80101_C0A80102_0035_1234;

        rst = 1'b1;
        req_valid = 1'b0; req_key = '0; req_flag = '0; req_id = '0;
        out_valid = 1'b0; out_flag = '0;
        #1;
        assert_reset();
        release_reset();

        // Single lookup, then push+pop at occupancy 3.
        tbl[0]  = mk(1, ka, KVS_OP_LOOKUP, 8'd5,  0, 4'd0, 1, 0, 8'd0,  4'd0);
        tbl[1]  = mk(0, '0, 4'd0,          8'd0,  0, 4'd0, 0, 0, 8'd0,  4'd0);
        tbl[2]  = mk(0, '0, 4'd0,          8'd0,  0, 4'd0, 0, 0, 8'd0,  4'd0);
        tbl[3]  = mk(0, '0, 4'd0,          8'd0,  0, 4'd0, 0, 0, 8'd0,  4'd0);
        tbl[4]  = mk(0, '0, 4'd0,          8'd0,  1, 4'd1, 0, 1, 8'd5,  4'd1);
        tbl[5]  = mk(1, kb, KVS_OP_INSERT, 8'd20, 0, 4'd0, 1, 0, 8'd0,  4'd0);
        tbl[6]  = mk(1, kb, KVS_OP_DELETE, 8'd21, 0, 4'd0, 1, 0, 8'd0,  4'd0);
        tbl[7]  = mk(1, ka, KVS_OP_LOOKUP, 8'd22, 0, 4'd0, 1, 0, 8'd0,  4'd0);
        tbl[8]  = mk(1, kb, KVS_OP_LOOKUP, 8'd23, 1, 4'd2, 1, 1, 8'd20, 4'd2);
        tbl[9]  = mk(0, '0, 4'd0,          8'd0,  1, 4'd3, 0, 1, 8'd21, 4'd3);
        tbl[10] = mk(0, '0, 4'd0,          8'd0,  1, 4'd4, 0, 1, 8'd22, 4'd4);
        tbl[11] = mk(0, '0, 4'd0,          8'd0,  1, 4'd5, 0, 1, 8'd23, 4'd5);
        tbl[12] = mk(0, '0, 4'd0,          8'd0,  0, 4'd0, 0, 0, 8'd0,  4'd0);
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rv, tbl[i].key, tbl[i].flag, tbl[i].id, tbl[i].ov, tbl[i].of);
            chk("tbl_in_valid", 128'(in_valid), 128'(tbl[i].x_inv));
            if (tbl[i].x_inv) chk("tbl_in_key", 128'(in_key), 128'(tbl[i].key));
            chk("tbl_rsp_valid", 128'(rsp_valid), 128'(tbl[i].x_rv));
            if (tbl[i].x_rv) begin
                chk("tbl_rsp_id", 128'(rsp_id), 128'(tbl[i].x_id));
                chk("tbl_rsp_flag", 128'(rsp_flag), 128'(tbl[i].x_flag));
                chk("tbl_hit", 128'(rsp_is_hit(rsp_flag)), 128'(tbl[i].x_flag[KVS_RSP_HIT]));
            end
        end

        // Burst fill to DEPTH, then drain in order.
        for (int i = 0; i < int'(DEPTH); i++) begin
            cycle(1'b1, {$urandom, $urandom, $urandom}, KVS_OP_LOOKUP, IW'(i), 1'b0, 4'd0);
            if (i == int'(DEPTH) - 2) chk("burst_ready_before_full", 128'(req_ready), 128'(1));
        end
        chk("burst_ready_full", 128'(req_ready), 128'(0));
        cycle(1'b1, kb, KVS_OP_LOOKUP, 8'd99, 1'b1, 4'd1);
        chk("full_push_blocked", 128'(in_valid), 128'(0));
        chk("burst_first_id", 128'(rsp_id), 128'(0));
        chk("ready_after_first_pop", 128'(req_ready), 128'(1));
        for (int i = 1; i < int'(DEPTH); i++) begin
            cycle(1'b0, '0, 4'd0, '0, 1'b1, 4'(i));
            chk("burst_order", 128'(rsp_id), 128'(i));
        end
        idle();

        // Orphan response with nothing outstanding; sticky until reset.
        cycle(1'b0, '0, 4'd0, '0, 1'b1, 4'd1);
        chk("orphan_set", 128'(err_orphan), 128'(1));
        chk("orphan_no_rsp", 128'(rsp_valid), 128'(0));
        for (int i = 0; i < 3; i++) idle();
        chk("orphan_sticky", 128'(err_orphan), 128'(1));

        // Reset with four queries outstanding; in-flight answers become orphans.
        assert_reset();
        release_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, ka, KVS_OP_LOOKUP, IW'(40 + i), 1'b0, 4'd0);
        #1;
        assert_reset();
        release_reset();
        chk("rst_mid_ready", 128'(req_ready), 128'(1));
        cycle(1'b0, '0, 4'd0, '0, 1'b1, 4'd1);
        chk("rst_mid_orphan", 128'(err_orphan), 128'(1));
        chk("rst_mid_no_rsp", 128'(rsp_valid), 128'(0));
        assert_reset();
        release_reset();

`ifdef KVS_QUERY_TIMEOUT_EN
        // Timeout of id 9, late response discarded, next query maps correctly.
        cycle(1'b1, ka, KVS_OP_LOOKUP, 8'd9, 1'b0, 4'd0);
        n = 0; found = 1'b0;
        while (!found && n < 20) begin
            idle();
            n++;
            if (rsp_valid) found = 1'b1;
        end
        chk("tmo_latency", 128'(n), 128'(8));
        chk("tmo_id", 128'(rsp_id), 128'(9));
        chk("tmo_bit", 128'(rsp_timeout), 128'(1));
        chk("tmo_flag", 128'(rsp_flag), 128'(0));
        cycle(1'b0, '0, 4'd0, '0, 1'b1, 4'd1);
        chk("late_discard", 128'(rsp_valid), 128'(0));
        chk("late_no_orphan", 128'(err_orphan), 128'(0));
        cycle(1'b1, kb, KVS_OP_LOOKUP, 8'd10, 1'b0, 4'd0);
        idle();
        idle();
        cycle(1'b0, '0, 4'd0, '0, 1'b1, 4'd1);
        chk("after_tmo_id", 128'(rsp_id), 128'(10));
        chk("after_tmo_flag", 128'(rsp_flag), 128'(1));
        chk("after_tmo_bit", 128'(rsp_timeout), 128'(0));
        assert_reset();
        release_reset();
`else
        n = 0; found = 1'b0;
`endif

        // Randomized traffic; database answers in order, speed varies by phase.
        for (int i = 0; i < 1500; i++) begin
            bit rv, ov;
            int p;
            p  = 2 + 3 * ((i / 300) % 3);
            rv = ($urandom_range(0, 9) < 6);
            ov = (db_pend > 0) && ($urandom_range(0, 9) < p);
            if (ov) db_pend--;
            if (rv && m_ready) db_pend++;
            cycle(rv, {$urandom, $urandom, $urandom}, ops[$urandom_range(0, 2)],
                  IW'($urandom), ov, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
